// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared select encodings, XLEN legality check and the
// immediate entry bundle used by the immediate-generation stage.
package imm_gen_pkg;

  localparam logic [2:0] SEL_I     = 3'd0;
  localparam logic [2:0] SEL_S     = 3'd1;
  localparam logic [2:0] SEL_B     = 3'd2;
  localparam logic [2:0] SEL_U     = 3'd3;
  localparam logic [2:0] SEL_J     = 3'd4;
  localparam logic [2:0] SEL_SHAMT = 3'd5;
  localparam logic [2:0] SEL_ZIMM  = 3'd6;
  localparam logic [2:0] SEL_ILL   = 3'd7;

  // Widest datapath and reference tag width an entry can describe.
  localparam int XLEN_MAX  = 64;
  localparam int TAG_REF_W = 32;

  // Only RV32 and RV64 datapaths are meaningful for this stage.
  function automatic bit xlen_ok(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

  // One generated immediate together with its sideband information.
  typedef struct packed {
    logic [XLEN_MAX-1:0]  imm;
    logic [TAG_REF_W-1:0] tag;
    logic                 illegal;
  } imm_entry;

endpackage

// File: rtl/imm_gen_comb.sv
// imm_gen_comb: purely combinational instruction + format select to
// XLEN-bit immediate decoder. Select 7 yields zero with the illegal flag.
module imm_gen_comb
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  logic [2:0]      sel,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // The opcode field never contributes to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^inst[6:0];

  // Signed casts sign-extend formats 0-4 from their top bit; unsigned casts
  // zero-extend the shift amount and CSR zimm.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (sel)
      SEL_I:     imm = XLEN'($signed(inst[31:20]));
      SEL_S:     imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      SEL_B:     imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      SEL_U:     imm = XLEN'($signed({inst[31:12], 12'b0}));
      SEL_J:     imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      SEL_SHAMT: imm = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
      SEL_ZIMM:  imm = XLEN'(inst[19:15]);
      SEL_ILL:   illegal = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate-generation stage with valid/ready
// handshake, flush and synchronous reset. Defining IMM_GEN_SKID_EN adds a
// one-entry skid buffer so in_ready no longer depends on out_ready.
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam bit XLEN_LEGAL = xlen_ok(XLEN);

  if (!XLEN_LEGAL) begin : g_xlen_check
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] gen_imm;
  logic            gen_illegal;
  logic            accept;

  imm_gen_comb #(.XLEN(XLEN)) u_comb (
    .inst    (in_inst),
    .sel     (in_sel),
    .imm     (gen_imm),
    .illegal (gen_illegal)
  );

`ifdef IMM_GEN_SKID_EN

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_illegal;
  logic             out_free;

  assign in_ready = !skid_valid;
  assign accept   = in_valid && !skid_valid;
  assign out_free = !out_valid || out_ready;

  // Output register refills from the skid first so order is kept; a new entry
  // arriving while the output is stalled parks in the skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_tag      <= '0;
      out_illegal  <= 1'b0;
      skid_valid   <= 1'b0;
      skid_imm     <= '0;
      skid_tag     <= '0;
      skid_illegal <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid   <= 1'b1;
        out_imm     <= skid_imm;
        out_tag     <= skid_tag;
        out_illegal <= skid_illegal;
        skid_valid  <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        out_imm     <= gen_imm;
        out_tag     <= in_tag;
        out_illegal <= gen_illegal;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid   <= 1'b1;
      skid_imm     <= gen_imm;
      skid_tag     <= in_tag;
      skid_illegal <= gen_illegal;
    end
  end

`else

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Single pipeline register: load on accept, empty when drained, killed by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_imm     <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_imm     <= gen_imm;
      out_tag     <= in_tag;
      out_illegal <= gen_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Parametrised, registered immediate-generation stage between decode and execute. Takes a full instruction word, format select and tag (PC/ROB id). Emits the sign- or zero-extended XLEN-bit immediate through a valid/ready pipeline register with stall and flush. Adds RV64 support, CSR zimm, an illegal-select flag and backpressure.

Parameters:
XLEN, 32, datapath width; only 32 or 64 are legal.
TAG_W, 32, width of the sideband tag carried alongside the instruction.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous active-high reset.
flush  in  1  synchronous kill of all held entries.
in_valid  in  1  input entry valid.
in_ready  out  1  stage can accept an input this cycle.
in_inst  in  32  instruction word.
in_sel  in  3  format select (encoding below).
in_tag  in  TAG_W  sideband tag.
out_valid  out  1  output entry valid.
out_ready  in  1  consumer accepts the output this cycle.
out_imm  out  XLEN  generated immediate.
out_tag  out  TAG_W  tag of the output entry.
out_illegal  out  1  in_sel was 7 for this entry.

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high. These are fixed.
- Select encoding, with s = inst[31] replicated to XLEN:
  - 0 I: inst[31:20].
  - 1 S: {inst[31:25], inst[11:7]}.
  - 2 B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - 3 U: {inst[31:12], 12'b0}, sign-extended for XLEN=64.
  - 4 J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - 5 shamt, zero-extended: inst[24:20] for XLEN=32, inst[25:20] for XLEN=64.
  - 6 zimm, zero-extended: inst[19:15].
  - 7 imm=0 and out_illegal=1.
- Formats 0-4 are sign-extended from their top bit.
- Transfer occurs when valid and ready are both high on the same edge.
- Latency is 1 cycle: an input accepted at edge N appears on out_* after edge N.
- out_* is held stable while out_valid=1 and out_ready=0.
- in_ready = !out_valid || out_ready (combinational path).
- Simultaneous accept and drain: the output register is replaced with the new entry and out_valid stays 1.
- flush: on the edge where it is high, out_valid goes to 0 and the input offered in that same cycle is discarded. flush overrides everything except rst.
- Reset values: out_valid=0, out_imm=0, out_tag=0, out_illegal=0.
- Reset mid-stall drops the held entry; in_ready=1 after reset.
- Data registers may load only when an entry is accepted; their value is unspecified-but-stable while out_valid=0.

Optional Feature:
IMM_GEN_SKID_EN
- Defined: adds a 1-entry skid buffer so in_ready is a registered signal with no combinational path from out_ready.
  - in_ready = !skid_valid.
  - An input accepted while the output is stalled goes into the skid.
  - When the output drains, the skid moves to the output on the next edge.
  - Order is preserved; throughput is 1 per cycle.
  - flush or rst clears both skid and output.
- Undefined: single register with combinational in_ready, as described above.

Decomposition:
- Shared package imm_gen_pkg holds:
  - SEL_I..SEL_ILL localparams (3'd0..3'd7);
  - XLEN legality check constant;
  - an imm_entry struct {imm, tag, illegal}.
- One sub-module, imm_gen_comb: purely combinational inst+sel -> imm+illegal, parametrised by XLEN. It is instantiated once at the stage input.

Test Plan:
- XLEN=32, I/S/B:
  - 0xFFF00093, sel0 -> 0xFFFFFFFF;
  - 0xFE20AE23, sel1 -> 0xFFFFFFFC;
  - 0xFE000CE3, sel2 -> 0xFFFFFFF8.
  - Each appears one cycle after acceptance.
- J, U and sel 7:
  - 0x0010006F, sel4 -> 0x00000800;
  - XLEN=64, 0x800000B7, sel3 -> 0xFFFFFFFF80000000;
  - sel7 -> imm 0, out_illegal=1.
- Shamt/zimm:
  - XLEN=64, inst[25:20]=6'h3F, sel5 -> 0x3F (XLEN=32 gives 0x1F);
  - inst[19:15]=5'h1F, sel6 -> 0x1F, not sign-extended.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 and distinct tags.
  - Output stays at the first tag; in_ready=0 (skid: accepts exactly one more, then 0).
  - On release, tags emerge in order with no loss or duplication.
- Flush: assert flush with out_valid=1 and a new input offered.
  - Next cycle out_valid=0 and the offered tag never appears.
- Reset mid-stall: rst with a held entry -> out_valid=0, out_imm=0, out_tag=0, in_ready=1 the following cycle.
